// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory responder for the core's MEM stage.
// Word RAM plus an MMIO page at 0x8000_0000 (LEDs, synchronised switches,
// free-running cycle counter, sticky bus-error flag).
// Define DMEM_MMIO_TIMER_EN to build the reload timer (TLOAD/TCNT/TCTRL) and IRQ.
module dmem_mmio #(
    parameter int unsigned address_size = 32,
    parameter int unsigned data_size    = 1024,
    parameter int unsigned io_width     = 10
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [address_size-1:0] daddr,
    input  logic [address_size-1:0] ddata_w,
    output logic [address_size-1:0] ddata_r,
    input  logic [io_width-1:0]     SW,
    output logic [io_width-1:0]     LEDR,
    output logic                    IRQ,
    output logic                    ERR
);
    localparam int unsigned AW    = address_size;
    localparam int unsigned IDX_W = $clog2(data_size);
    localparam int unsigned OFS_W = AW - 3;

    localparam logic [OFS_W-1:0] OFS_LED   = OFS_W'(0);
    localparam logic [OFS_W-1:0] OFS_SW    = OFS_W'(1);
    localparam logic [OFS_W-1:0] OFS_CYC   = OFS_W'(2);
    localparam logic [OFS_W-1:0] OFS_TLOAD = OFS_W'(3);
    localparam logic [OFS_W-1:0] OFS_TCNT  = OFS_W'(4);
    localparam logic [OFS_W-1:0] OFS_TCTRL = OFS_W'(5);

    logic             is_mmio;
    logic             ram_hit;
    logic [IDX_W-1:0] ram_idx;
    logic [OFS_W-1:0] mmio_ofs;
    logic             sel_led;
    logic             sel_sw;
    logic             sel_cyc;
    logic             sel_tload;
    logic             sel_tcnt;
    logic             sel_tctrl;
    logic             mmio_hit;
    logic             bus_err;
    logic [1:0]       unused_byte_ofs;

    logic [AW-1:0]       mem [data_size];
    logic [AW-1:0]       rdata_c;
    logic [io_width-1:0] led_q;
    logic [io_width-1:0] led_d;
    logic [io_width-1:0] sw_meta_q;
    logic [io_width-1:0] sw_sync_q;
    logic [AW-1:0]       cycle_q;
    logic                err_q;
    logic                err_d;

    logic [AW-1:0] tload_rd;
    logic [AW-1:0] tcnt_rd;
    logic [2:0]    tctrl_lo;

    // Address decode: bit 31 picks MMIO, byte offset bits are ignored
    assign unused_byte_ofs = daddr[1:0];
    assign is_mmio   = daddr[AW-1];
    assign ram_idx   = daddr[IDX_W+1:2];
    assign ram_hit   = ~is_mmio & ~(|daddr[AW-2:IDX_W+2]);
    assign mmio_ofs  = daddr[AW-2:2];
    assign sel_led   = is_mmio & (mmio_ofs == OFS_LED);
    assign sel_sw    = is_mmio & (mmio_ofs == OFS_SW);
    assign sel_cyc   = is_mmio & (mmio_ofs == OFS_CYC);
    assign sel_tload = is_mmio & (mmio_ofs == OFS_TLOAD);
    assign sel_tcnt  = is_mmio & (mmio_ofs == OFS_TCNT);
    assign sel_tctrl = is_mmio & (mmio_ofs == OFS_TCTRL);
    // Timer offsets are legal addresses even when the timer is not built
    assign mmio_hit  = sel_led | sel_sw | sel_cyc | sel_tload | sel_tcnt | sel_tctrl;
    assign bus_err   = (MemRead | MemWrite) & (is_mmio ? ~mmio_hit : ~ram_hit);

`ifdef DMEM_MMIO_TIMER_EN
    logic [AW-1:0] tload_q;
    logic [AW-1:0] tload_d;
    logic [AW-1:0] tcnt_q;
    logic [AW-1:0] tcnt_d;
    logic          ten_q;
    logic          ten_d;
    logic          tirqen_q;
    logic          tirqen_d;
    logic          tflag_q;
    logic          tflag_d;
    logic          expire_c;

    // Timer next state: count/reload, bus writes, flag set beats write-1-clear
    always_comb begin
        tload_d  = tload_q;
        tcnt_d   = tcnt_q;
        ten_d    = ten_q;
        tirqen_d = tirqen_q;
        tflag_d  = tflag_q;
        expire_c = ten_q && (tcnt_q == '0);
        if (ten_q) begin
            tcnt_d = expire_c ? tload_q : tcnt_q - AW'(1);
        end
        if (MemWrite && sel_tload) begin
            tload_d = ddata_w;
            tcnt_d  = ddata_w;
        end
        if (MemWrite && sel_tctrl) begin
            ten_d    = ddata_w[0];
            tirqen_d = ddata_w[1];
            if (ddata_w[2]) begin
                tflag_d = 1'b0;
            end
        end
        if (expire_c) begin
            tflag_d = 1'b1;
        end
    end

    // Timer registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tload_q  <= '0;
            tcnt_q   <= '0;
            ten_q    <= 1'b0;
            tirqen_q <= 1'b0;
            tflag_q  <= 1'b0;
        end else begin
            tload_q  <= tload_d;
            tcnt_q   <= tcnt_d;
            ten_q    <= ten_d;
            tirqen_q <= tirqen_d;
            tflag_q  <= tflag_d;
        end
    end

    assign IRQ      = tflag_q & tirqen_q;
    assign tload_rd = tload_q;
    assign tcnt_rd  = tcnt_q;
    assign tctrl_lo = {tflag_q, tirqen_q, ten_q};
`else
    assign IRQ      = 1'b0;
    assign tload_rd = '0;
    assign tcnt_rd  = '0;
    assign tctrl_lo = 3'b000;
`endif

    // LED and sticky error next state; a new error beats write-1-clear
    always_comb begin
        led_d = led_q;
        err_d = err_q;
        if (MemWrite && sel_led) begin
            led_d = ddata_w[io_width-1:0];
        end
        if (MemWrite && sel_tctrl && ddata_w[3]) begin
            err_d = 1'b0;
        end
        if (bus_err) begin
            err_d = 1'b1;
        end
    end

    // MMIO registers, switch synchroniser and cycle counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cycle_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
            cycle_q   <= cycle_q + AW'(1);
            err_q     <= err_d;
        end
    end

    // RAM write port; contents survive reset but writes during reset are dropped
    always_ff @(posedge CLK) begin
        if (!RESET && MemWrite && ram_hit) begin
            mem[ram_idx] <= ddata_w;
        end
    end

    // Zero-latency read mux, forced to zero when no read is requested
    always_comb begin
        rdata_c = '0;
        if (!is_mmio) begin
            if (ram_hit) begin
                rdata_c = mem[ram_idx];
            end
        end else if (sel_led) begin
            rdata_c = AW'(led_q);
        end else if (sel_sw) begin
            rdata_c = AW'(sw_sync_q);
        end else if (sel_cyc) begin
            rdata_c = cycle_q;
        end else if (sel_tload) begin
            rdata_c = tload_rd;
        end else if (sel_tcnt) begin
            rdata_c = tcnt_rd;
        end else if (sel_tctrl) begin
            rdata_c = AW'({err_q, tctrl_lo});
        end
        ddata_r = MemRead ? rdata_c : '0;
    end

    assign LEDR = led_q;
    assign ERR  = err_q;

endmodule
